// File: rtl/bp_pht_update_arbiter.sv
// Update-port scheduler for the shared 2-bit counter table: sweeps a full clear,
// then drains per-requester update FIFOs round-robin into the single write port.
module bp_pht_update_arbiter #(
  parameter int INDEX  = 12,
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              clr_req,
  input  logic              g_valid,
  input  logic [INDEX-1:0]  g_idx,
  input  logic              g_taken,
  input  logic              l_valid,
  input  logic [INDEX-1:0]  l_idx,
  input  logic              l_taken,
  output logic              pht_we,
  output logic              pht_clr,
  output logic [INDEX-1:0]  pht_idx,
  output logic              pht_up_down,
  output logic              busy,
  output logic              g_full,
  output logic              l_full,
  output logic [DROP_W-1:0] g_drops,
  output logic [DROP_W-1:0] l_drops
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t             state_reg;
  logic [INDEX-1:0]   clr_idx_reg;
  logic               rr_reg;         // 0 = global side served next on contention
  logic               busy_reg;
  logic               pht_we_reg;
  logic               pht_clr_reg;
  logic [INDEX-1:0]   pht_idx_reg;
  logic               pht_up_down_reg;

  // Requester 0 = global predictor, requester 1 = local predictor.
  logic [1:0]         in_valid;
  logic [1:0]         in_taken;
  logic [INDEX-1:0]   in_idx [2];
  logic [1:0]         not_empty;
  logic [1:0]         deq;
  logic [1:0]         full_w;
  logic [1:0]         head_taken;
  logic [INDEX-1:0]   head_idx [2];
  logic [DROP_W-1:0]  drops_w [2];
  logic               active;
  logic               sel;

  assign in_valid  = {l_valid, g_valid};
  assign in_taken  = {l_taken, g_taken};
  assign in_idx[0] = g_idx;
  assign in_idx[1] = l_idx;

  // Stall freezes everything; clr_req flushes instead of enqueuing/dequeuing.
  assign active = !stall && !clr_req;

  always_comb begin
    deq = 2'b00;
    if (active && state_reg == ST_RUN) begin
      if (not_empty == 2'b11) begin
        deq[rr_reg] = 1'b1;
      end else begin
        deq = not_empty;
      end
    end
  end

  assign sel = deq[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [INDEX:0]      mem [DEPTH];
      logic [PW-1:0]       wr_ptr_reg;
      logic [PW-1:0]       rd_ptr_reg;
      logic [CW-1:0]       count_reg;
      logic [CW-1:0]       count_next;
      logic                full_reg;
      logic [DROP_W-1:0]   drops_reg;
      logic                enq;

      // A full FIFO still accepts when its head leaves on the same edge.
      always_comb begin
        enq        = in_valid[gi] && ((count_reg < CW'(DEPTH)) || deq[gi]);
        count_next = count_reg + CW'(enq) - CW'(deq[gi]);
      end

      always_ff @(posedge clk) begin
        if (active && enq) begin
          mem[wr_ptr_reg] <= {in_taken[gi], in_idx[gi]};
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
          full_reg   <= 1'b0;
          drops_reg  <= '0;
        end else if (!stall) begin
          if (clr_req) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
          end else begin
            if (enq) begin
              wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (deq[gi]) begin
              rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
            full_reg  <= (count_next == CW'(DEPTH));
            if (in_valid[gi] && !enq && drops_reg != {DROP_W{1'b1}}) begin
              drops_reg <= drops_reg + 1'b1;
            end
          end
        end
      end

      assign not_empty[gi]                  = (count_reg != '0);
      assign full_w[gi]                     = full_reg;
      assign drops_w[gi]                    = drops_reg;
      assign {head_taken[gi], head_idx[gi]} = mem[rd_ptr_reg];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= ST_CLEAR;
      clr_idx_reg     <= '0;
      rr_reg          <= 1'b0;
      busy_reg        <= 1'b0;
      pht_we_reg      <= 1'b0;
      pht_clr_reg     <= 1'b0;
      pht_idx_reg     <= '0;
      pht_up_down_reg <= 1'b0;
    end else if (stall) begin
      pht_we_reg  <= 1'b0;
      pht_clr_reg <= 1'b0;
    end else if (clr_req) begin
      state_reg   <= ST_CLEAR;
      clr_idx_reg <= '0;
      busy_reg    <= 1'b1;
      pht_we_reg  <= 1'b0;
      pht_clr_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_CLEAR: begin
          pht_we_reg  <= 1'b1;
          pht_clr_reg <= 1'b1;
          pht_idx_reg <= clr_idx_reg;
          clr_idx_reg <= clr_idx_reg + 1'b1;
          // busy falls on the same edge that issues the last clear write.
          if (clr_idx_reg == {INDEX{1'b1}}) begin
            state_reg <= ST_RUN;
            busy_reg  <= 1'b0;
          end else begin
            busy_reg  <= 1'b1;
          end
        end
        default: begin
          pht_clr_reg <= 1'b0;
          if (deq != 2'b00) begin
            pht_we_reg      <= 1'b1;
            pht_idx_reg     <= head_idx[sel];
            pht_up_down_reg <= head_taken[sel];
            if (not_empty == 2'b11) begin
              rr_reg <= ~rr_reg;
            end
          end else begin
            pht_we_reg <= 1'b0;
          end
        end
      endcase
    end
  end

  assign pht_we      = pht_we_reg;
  assign pht_clr     = pht_clr_reg;
  assign pht_idx     = pht_idx_reg;
  assign pht_up_down = pht_up_down_reg;
  assign busy        = busy_reg;
  assign g_full      = full_w[0];
  assign l_full      = full_w[1];
  assign g_drops     = drops_w[0];
  assign l_drops     = drops_w[1];

endmodule

// File: tb/tb_bp_pht_update_arbiter.sv
// Directed bench for bp_pht_update_arbiter: clear sweep, latency, round-robin,
// stall freeze, FIFO overflow/drops and clr_req flush.
module tb_bp_pht_update_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, clr_req;
  logic        g_valid, g_taken, l_valid, l_taken;
  logic [11:0] g_idx, l_idx;
  logic        pht_we, pht_clr, pht_up_down, busy, g_full, l_full;
  logic [11:0] pht_idx;
  logic [7:0]  g_drops, l_drops;

  int vectors = 0;
  int miscompares = 0;

  bp_pht_update_arbiter #(.INDEX(12), .DEPTH(4), .DROP_W(8)) dut (
    .clk(clk), .reset(reset), .stall(stall), .clr_req(clr_req),
    .g_valid(g_valid), .g_idx(g_idx), .g_taken(g_taken),
    .l_valid(l_valid), .l_idx(l_idx), .l_taken(l_taken),
    .pht_we(pht_we), .pht_clr(pht_clr), .pht_idx(pht_idx), .pht_up_down(pht_up_down),
    .busy(busy), .g_full(g_full), .l_full(l_full), .g_drops(g_drops), .l_drops(l_drops)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {we, clr, up_down, idx}
  function automatic logic [31:0] port_word(input logic we, input logic clr,
                                            input logic ud, input logic [11:0] idx);
    return {17'd0, we, clr, ud, idx};
  endfunction

  logic [31:0] obs;
  assign obs = port_word(pht_we, pht_clr, pht_up_down, pht_idx);

  initial begin
    int exp_i;
    int stall_done;
    int lk;
    int cyc;
    bit stalled_prev;
    logic [11:0] exp3 [6];
    logic        ud3  [6];

    reset = 1'b0; stall = 1'b0; clr_req = 1'b0;
    g_valid = 1'b0; g_idx = '0; g_taken = 1'b0;
    l_valid = 1'b0; l_idx = '0; l_taken = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_port", obs, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_full", {30'd0, g_full, l_full}, 32'd0);
    check("rst_drops", {16'd0, g_drops, l_drops}, 32'd0);
    reset = 1'b1;

    // 1: full clear sweep after reset
    for (int i = 0; i < 4096; i++) begin
      @(negedge clk);
      check("sweep1", obs, port_word(1'b1, 1'b1, 1'b0, 12'(i)));
      if (i == 0) check("sweep1_busy", {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    check("after_sweep1_we", {31'd0, pht_we}, 32'd0);
    check("after_sweep1_busy", {31'd0, busy}, 32'd0);

    // 2: single global update, two-edge latency, one-cycle pulse
    g_valid = 1'b1; g_idx = 12'h0A5; g_taken = 1'b1;
    @(negedge clk);
    g_valid = 1'b0;
    check("lat_k", {31'd0, pht_we}, 32'd0);
    @(negedge clk);
    check("lat_k1", obs, port_word(1'b1, 1'b0, 1'b1, 12'h0A5));
    @(negedge clk);
    check("lat_pulse_end", {31'd0, pht_we}, 32'd0);

    // 3: round-robin with both requesters active
    exp3 = '{12'h001, 12'h101, 12'h002, 12'h102, 12'h003, 12'h103};
    ud3  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    g_valid = 1'b1; l_valid = 1'b1; g_taken = 1'b1; l_taken = 1'b0;
    g_idx = 12'h001; l_idx = 12'h101;
    @(negedge clk);
    g_idx = 12'h002; l_idx = 12'h102;
    @(negedge clk);
    check("rr0", obs, port_word(1'b1, 1'b0, ud3[0], exp3[0]));
    g_idx = 12'h003; l_idx = 12'h103;
    @(negedge clk);
    check("rr1", obs, port_word(1'b1, 1'b0, ud3[1], exp3[1]));
    g_valid = 1'b0; l_valid = 1'b0;
    for (int j = 2; j < 6; j++) begin
      @(negedge clk);
      check($sformatf("rr%0d", j), obs, port_word(1'b1, 1'b0, ud3[j], exp3[j]));
    end
    @(negedge clk);
    check("rr_idle", {31'd0, pht_we}, 32'd0);

    // 6: queue two entries, then clr_req flushes them
    g_valid = 1'b1; g_idx = 12'h055; g_taken = 1'b1;
    l_valid = 1'b1; l_idx = 12'h066; l_taken = 1'b1;
    @(negedge clk);
    g_valid = 1'b0; l_valid = 1'b0; clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    check("clrreq_we", {31'd0, pht_we}, 32'd0);
    check("clrreq_busy", {31'd0, busy}, 32'd1);

    // 4 + 5: second sweep with a 5-cycle stall at 100 and an l_valid burst
    exp_i = 0; stall_done = 0; lk = 0; cyc = 0; stalled_prev = 1'b0;
    l_taken = 1'b0;
    while (exp_i < 4096) begin
      @(negedge clk);
      cyc++;
      if (cyc > 6000) begin
        check("sweep2_timeout", 32'(exp_i), 32'd4096);
        break;
      end
      if (stalled_prev) begin
        check("stall_hold", obs & 32'h6FFF, port_word(1'b0, 1'b0, 1'b0, 12'(exp_i - 1)));
      end else begin
        check("sweep2", obs & 32'h6FFF, port_word(1'b1, 1'b1, 1'b0, 12'(exp_i)));
        exp_i++;
      end
      if (lk == 3) check("l_full_3", {31'd0, l_full}, 32'd0);
      if (lk == 4) check("l_full_4", {31'd0, l_full}, 32'd1);
      if (exp_i == 2000 && !stalled_prev) check("sweep2_busy", {31'd0, busy}, 32'd1);

      stall = 1'b0;
      stalled_prev = 1'b0;
      if (exp_i == 100 && stall_done < 5) begin
        stall = 1'b1;
        stalled_prev = 1'b1;
        stall_done++;
      end
      if (exp_i >= 200 && lk < 6) begin
        l_valid = 1'b1;
        l_idx   = 12'h200 + 12'(lk);
        l_taken = lk[0];
        lk++;
      end else begin
        l_valid = 1'b0;
      end
    end
    check("sweep2_writes", 32'(exp_i), 32'd4096);
    check("l_drops", {24'd0, l_drops}, 32'd2);
    check("g_drops", {24'd0, g_drops}, 32'd0);

    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("drain%0d", k), obs, port_word(1'b1, 1'b0, k[0], 12'h200 + 12'(k)));
    end
    @(negedge clk);
    check("drain_idle", {31'd0, pht_we}, 32'd0);
    check("drain_full", {31'd0, l_full}, 32'd0);
    check("drain_busy", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
